// File: rtl/eth_parser_pkg.sv
// Shared constants, state encoding and result-record layout for the Ethernet header parser.
package eth_parser_pkg;

    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

    localparam int FLAG_W = 6;
    localparam int VID_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_INNER,
        ST_SEARCH,
        ST_WRITE
    } parse_state_t;

    // Record layout, MSB first:
    // {is_for_us, is_arp, is_ip, is_broadcast, is_multicast, is_vlan, vlan_id[11:0], port}
    function automatic int rec_width(input int port_w);
        return FLAG_W + VID_W + port_w;
    endfunction

endpackage

// File: rtl/eth_hdr_result_fifo.sv
// Fallthrough FIFO of classification records; head is visible while not empty, zero otherwise.
module eth_hdr_result_fifo #(
    parameter int WIDTH      = 21,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_rd;
    logic                  do_wr;

    assign full    = (count == (DEPTH_BITS + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_hdr_parser.sv
// Per-packet Ethernet header parser: captures DA/ethertype, searches the port MAC table, queues a record.
// Optional 802.1Q tag handling is built when ETH_HDR_PARSER_VLAN_EN is defined.
module eth_hdr_parser
    import eth_parser_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int NUM_MAC_PORTS    = 4,
    parameter int NUM_QUEUES       = 8,
    parameter int NUM_QUEUES_WIDTH = $clog2(NUM_QUEUES),
    parameter int FIFO_DEPTH_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          word_MAC_DA,
    input  logic                          word_ETH_TYPE,
    input  logic                          word_VLAN_INNER,
    input  logic [48*NUM_MAC_PORTS-1:0]   mac_table,
    input  logic                          eth_parser_rd_info,
    output logic                          eth_parser_info_vld,
    output logic                          is_for_us,
    output logic                          is_arp_pkt,
    output logic                          is_ip_pkt,
    output logic                          is_broadcast,
    output logic                          is_multicast,
    output logic                          is_vlan,
    output logic [11:0]                   vlan_id,
    output logic [NUM_QUEUES_WIDTH-1:0]   mac_dst_port_num,
    output logic                          parse_overrun,
    output logic [15:0]                   overrun_count
);

    localparam int REC_W = rec_width(NUM_QUEUES_WIDTH);
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MAC_PORTS - 1);

    parse_state_t                state;
    logic [47:0]                 da;
    logic [15:0]                 eth_type;
    logic [11:0]                 vid;
    logic                        vlan_seen;
    logic [IDX_W-1:0]            idx;
    logic                        rec_for_us;
    logic                        rec_bcast;
    logic                        rec_mcast;
    logic [NUM_QUEUES_WIDTH-1:0] rec_port;
    logic [47:0]                 cur_mac;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push_ok;
    logic                        fifo_wr;
    logic [REC_W-1:0]            rec_in;
    logic [REC_W-1:0]            rec_out;

`ifdef ETH_HDR_PARSER_VLAN_EN
    logic unused_in_bits;
    assign unused_in_bits = ^in_data[15:12];
`else
    logic unused_in_bits;
    assign unused_in_bits = ^{word_VLAN_INNER, in_data[15:0]};
`endif

    always_comb begin
        cur_mac = '0;
        for (int i = 0; i < NUM_MAC_PORTS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_mac = mac_table[48*i +: 48];
            end
        end
    end

    assign push_ok = !fifo_full || eth_parser_rd_info;
    assign fifo_wr = (state == ST_WRITE) && push_ok;
    assign rec_in  = {rec_for_us, eth_type == ETH_TYPE_ARP, eth_type == ETH_TYPE_IP,
                      rec_bcast, rec_mcast, vlan_seen, vid, rec_port};

    // Overrun tracking runs alongside the FSM; a DA strobe outside IDLE never disturbs the search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            da            <= '0;
            eth_type      <= '0;
            vid           <= '0;
            vlan_seen     <= 1'b0;
            idx           <= '0;
            rec_for_us    <= 1'b0;
            rec_bcast     <= 1'b0;
            rec_mcast     <= 1'b0;
            rec_port      <= '0;
            parse_overrun <= 1'b0;
            overrun_count <= '0;
        end else begin
            parse_overrun <= 1'b0;
            if (word_MAC_DA && state != ST_IDLE) begin
                parse_overrun <= 1'b1;
                if (overrun_count != 16'hFFFF) begin
                    overrun_count <= overrun_count + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (word_MAC_DA) begin
                        da <= in_data[63:16];
                    end
                    if (word_ETH_TYPE) begin
                        eth_type   <= in_data[31:16];
                        idx        <= '0;
                        rec_for_us <= 1'b0;
                        rec_bcast  <= 1'b0;
                        rec_mcast  <= 1'b0;
                        rec_port   <= '0;
`ifdef ETH_HDR_PARSER_VLAN_EN
                        if (in_data[31:16] == ETH_TYPE_VLAN) begin
                            vlan_seen <= 1'b1;
                            vid       <= in_data[11:0];
                            state     <= ST_WAIT_INNER;
                        end else begin
                            vlan_seen <= 1'b0;
                            vid       <= '0;
                            state     <= ST_SEARCH;
                        end
`else
                        state <= ST_SEARCH;
`endif
                    end
                end

                ST_WAIT_INNER: begin
`ifdef ETH_HDR_PARSER_VLAN_EN
                    if (word_VLAN_INNER) begin
                        eth_type <= in_data[63:48];
                        state    <= ST_SEARCH;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                // Group addresses bypass the table entirely.
                ST_SEARCH: begin
                    if (da[40]) begin
                        rec_for_us <= 1'b1;
                        rec_port   <= '0;
                        rec_bcast  <= (da == 48'hFFFF_FFFF_FFFF);
                        rec_mcast  <= (da != 48'hFFFF_FFFF_FFFF);
                        state      <= ST_WRITE;
                    end else if (cur_mac == da) begin
                        rec_for_us <= 1'b1;
                        rec_port   <= NUM_QUEUES_WIDTH'({idx, 1'b0});
                        state      <= ST_WRITE;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_WRITE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (push_ok) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    eth_hdr_result_fifo #(
        .WIDTH      (REC_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_result_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (rec_in),
        .rd_en   (eth_parser_rd_info),
        .rd_data (rec_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign eth_parser_info_vld = !fifo_empty;
    assign {is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast, is_multicast,
            is_vlan, vlan_id, mac_dst_port_num} = rec_out;

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Scoreboard bench for eth_hdr_parser; expectations come from a small behavioural model of the header rules.
module tb_eth_hdr_parser;

    logic         clk;
    logic         reset;
    logic [63:0]  in_data;
    logic         word_MAC_DA;
    logic         word_ETH_TYPE;
    logic         word_VLAN_INNER;
    logic [191:0] mac_table;
    logic         eth_parser_rd_info;
    logic         eth_parser_info_vld;
    logic         is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast, is_multicast, is_vlan;
    logic [11:0]  vlan_id;
    logic [2:0]   mac_dst_port_num;
    logic         parse_overrun;
    logic [15:0]  overrun_count;

    logic [47:0]  port_mac [4];
    logic [20:0]  sb [$];
    logic [20:0]  exp_rec;
    int           checks;
    int           passed;
    int           lat;

    eth_hdr_parser dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .word_MAC_DA         (word_MAC_DA),
        .word_ETH_TYPE       (word_ETH_TYPE),
        .word_VLAN_INNER     (word_VLAN_INNER),
        .mac_table           (mac_table),
        .eth_parser_rd_info  (eth_parser_rd_info),
        .eth_parser_info_vld (eth_parser_info_vld),
        .is_for_us           (is_for_us),
        .is_arp_pkt          (is_arp_pkt),
        .is_ip_pkt           (is_ip_pkt),
        .is_broadcast        (is_broadcast),
        .is_multicast        (is_multicast),
        .is_vlan             (is_vlan),
        .vlan_id             (vlan_id),
        .mac_dst_port_num    (mac_dst_port_num),
        .parse_overrun       (parse_overrun),
        .overrun_count       (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mac_table = {port_mac[3], port_mac[2], port_mac[1], port_mac[0]};

    function automatic logic [20:0] observed();
        return {is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast, is_multicast,
                is_vlan, vlan_id, mac_dst_port_num};
    endfunction

    function automatic logic [20:0] model_rec(input logic [47:0] d, input logic [15:0] t,
                                              input logic [15:0] tci, input logic [15:0] inner);
        logic fu, bc, mc, vl;
        logic [11:0] v;
        logic [2:0]  p;
        logic [15:0] et;
        fu = 1'b0; bc = 1'b0; mc = 1'b0; p = 3'd0;
`ifdef ETH_HDR_PARSER_VLAN_EN
        vl = (t == 16'h8100);
        v  = vl ? tci[11:0] : 12'h0;
        et = vl ? inner : t;
`else
        begin
            logic unused_args;
            unused_args = ^{tci, inner};
        end
        vl = 1'b0;
        v  = 12'h0;
        et = t;
`endif
        if (d[40]) begin
            fu = 1'b1;
            bc = (d == 48'hFFFF_FFFF_FFFF);
            mc = !bc;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (port_mac[i] == d) begin
                    fu = 1'b1;
                    p  = 3'(2 * i);
                end
            end
        end
        return {fu, et == 16'h0806, et == 16'h0800, bc, mc, vl, v, p};
    endfunction

    // Drives DA, ethertype (and inner type for tagged frames); returns on the negedge after the type strobe.
    task automatic send_header(input logic [47:0] d, input logic [15:0] t,
                               input logic [15:0] tci, input logic [15:0] inner);
        sb.push_back(model_rec(d, t, tci, inner));
        word_MAC_DA = 1'b1;
        in_data     = {d, 16'h0};
        @(negedge clk);
        word_MAC_DA   = 1'b0;
        word_ETH_TYPE = 1'b1;
        in_data       = {32'h0, t, tci};
        @(negedge clk);
        word_ETH_TYPE = 1'b0;
        in_data       = '0;
        if (t == 16'h8100) begin
            word_VLAN_INNER = 1'b1;
            in_data         = {inner, 48'h0};
            @(negedge clk);
            word_VLAN_INNER = 1'b0;
            in_data         = '0;
        end
    endtask

    task automatic pop_head();
        eth_parser_rd_info = 1'b1;
        @(negedge clk);
        eth_parser_rd_info = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (eth_parser_info_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %b expected 0", eth_parser_info_vld);
        else passed++;
        checks++;
        if (parse_overrun !== 1'b0 || overrun_count !== 16'h0)
            $display("[TB] FAIL reset_overrun: got %b/%h expected 0/0000", parse_overrun, overrun_count);
        else passed++;
        checks++;
        if (observed() !== 21'h0) $display("[TB] FAIL reset_record: got %h expected 000000", observed());
        else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unicast_match();
        send_header(port_mac[2], 16'h0800, 16'h0, 16'h0);
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 4) $display("[TB] FAIL match2_latency: got %0d expected 4", lat);
        else passed++;
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL match2_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        checks++;
        if (observed() !== {6'b101000, 12'h0, 3'd4})
            $display("[TB] FAIL match2_fields: got %h expected %h", observed(), {6'b101000, 12'h0, 3'd4});
        else passed++;
        pop_head();
        checks++;
        if (eth_parser_info_vld !== 1'b0) $display("[TB] FAIL match2_pop: got vld %b expected 0", eth_parser_info_vld);
        else passed++;

        send_header(port_mac[0], 16'h0800, 16'h0, 16'h0);
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 2) $display("[TB] FAIL match0_latency: got %0d expected 2", lat);
        else passed++;
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL match0_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        pop_head();
    endtask

    task automatic test_broadcast();
        send_header(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0, 16'h0);
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 2) $display("[TB] FAIL bcast_latency: got %0d expected 2", lat);
        else passed++;
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL bcast_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        checks++;
        if (observed() !== {6'b110100, 12'h0, 3'd0})
            $display("[TB] FAIL bcast_fields: got %h expected %h", observed(), {6'b110100, 12'h0, 3'd0});
        else passed++;
        pop_head();
    endtask

    task automatic test_no_match();
        send_header(48'h0011_2233_4455, 16'h0800, 16'h0, 16'h0);
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 5) $display("[TB] FAIL nomatch_latency: got %0d expected 5", lat);
        else passed++;
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL nomatch_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        checks++;
        if (is_for_us !== 1'b0) $display("[TB] FAIL nomatch_for_us: got %b expected 0", is_for_us);
        else passed++;
        pop_head();
    endtask

    task automatic test_vlan();
        logic [20:0] want;
`ifdef ETH_HDR_PARSER_VLAN_EN
        want = {6'b101011, 12'h064, 3'd0};
`else
        want = {6'b100010, 12'h000, 3'd0};
`endif
        send_header(48'h0100_5E00_0001, 16'h8100, 16'h2064, 16'h0800);
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat >= 20) $display("[TB] FAIL vlan_timeout: got no record expected one within 20 cycles");
        else passed++;
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL vlan_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        checks++;
        if (observed() !== want) $display("[TB] FAIL vlan_fields: got %h expected %h", observed(), want);
        else passed++;
        pop_head();
    endtask

    task automatic test_overrun();
        send_header(port_mac[3], 16'h0806, 16'h0, 16'h0);
        word_MAC_DA = 1'b1;
        in_data     = {48'hFFFF_FFFF_FFFF, 16'h0};
        @(negedge clk);
        word_MAC_DA = 1'b0;
        checks++;
        if (parse_overrun !== 1'b1 || overrun_count !== 16'd1)
            $display("[TB] FAIL overrun_pulse: got %b/%0d expected 1/1", parse_overrun, overrun_count);
        else passed++;
        word_ETH_TYPE = 1'b1;
        in_data       = {32'h0, 16'h0800, 16'h0};
        @(negedge clk);
        word_ETH_TYPE = 1'b0;
        in_data       = '0;
        checks++;
        if (parse_overrun !== 1'b0) $display("[TB] FAIL overrun_single: got %b expected 0", parse_overrun);
        else passed++;
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL overrun_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        checks++;
        if (mac_dst_port_num !== 3'd6) $display("[TB] FAIL overrun_port: got %0d expected 6", mac_dst_port_num);
        else passed++;
        pop_head();
        repeat (8) @(negedge clk);
        checks++;
        if (eth_parser_info_vld !== 1'b0) $display("[TB] FAIL overrun_dropped: got vld %b expected 0", eth_parser_info_vld);
        else passed++;
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            send_header(port_mac[i], 16'h0800, 16'h0, 16'h0);
            repeat (6) @(negedge clk);
        end
        send_header(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0, 16'h0);
        repeat (10) @(negedge clk);
        checks++;
        if (eth_parser_info_vld !== 1'b1) $display("[TB] FAIL full_vld: got %b expected 1", eth_parser_info_vld);
        else passed++;
        word_MAC_DA = 1'b1;
        in_data     = {48'h0211_2233_4455, 16'h0};
        @(negedge clk);
        word_MAC_DA = 1'b0;
        in_data     = '0;
        checks++;
        if (parse_overrun !== 1'b1 || overrun_count !== 16'd2)
            $display("[TB] FAIL full_hold_in_write: got %b/%0d expected 1/2", parse_overrun, overrun_count);
        else passed++;
        for (int n = 0; n < 5; n++) begin
            exp_rec = sb.pop_front();
            checks++;
            if (observed() !== exp_rec)
                $display("[TB] FAIL full_order_%0d: got %h expected %h", n, observed(), exp_rec);
            else passed++;
            pop_head();
        end
        checks++;
        if (eth_parser_info_vld !== 1'b0) $display("[TB] FAIL full_drain: got vld %b expected 0", eth_parser_info_vld);
        else passed++;
    endtask

    task automatic test_reset_mid_search();
        send_header(port_mac[0], 16'h0800, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (eth_parser_info_vld !== 1'b1) $display("[TB] FAIL rst_pre_vld: got %b expected 1", eth_parser_info_vld);
        else passed++;
        send_header(48'h0011_2233_4455, 16'h0800, 16'h0, 16'h0);
        reset = 1'b0;
        #1;
        checks++;
        if (eth_parser_info_vld !== 1'b0 || overrun_count !== 16'h0)
            $display("[TB] FAIL rst_async: got vld %b count %0d expected 0/0", eth_parser_info_vld, overrun_count);
        else passed++;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_header(port_mac[0], 16'h0806, 16'h0, 16'h0);
        lat = 0;
        while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 2) $display("[TB] FAIL rst_idle_latency: got %0d expected 2", lat);
        else passed++;
        exp_rec = sb.pop_front();
        checks++;
        if (observed() !== exp_rec) $display("[TB] FAIL rst_record: got %h expected %h", observed(), exp_rec);
        else passed++;
        pop_head();
    endtask

    task automatic test_back_to_back();
        logic [47:0] d;
        logic [15:0] t;
        for (int n = 0; n < 4; n++) begin
            case ($urandom_range(0, 5))
                0: d = port_mac[0];
                1: d = port_mac[1];
                2: d = port_mac[2];
                3: d = port_mac[3];
                4: d = 48'hFFFF_FFFF_FFFF;
                default: d = {16'h025C, 32'($urandom)};
            endcase
            case ($urandom_range(0, 2))
                0: t = 16'h0800;
                1: t = 16'h0806;
                default: t = 16'h86DD;
            endcase
            send_header(d, t, 16'h0, 16'h0);
            repeat (5) @(negedge clk);
        end
        while (sb.size() > 0) begin
            lat = 0;
            while (!eth_parser_info_vld && lat < 20) begin @(negedge clk); lat++; end
            exp_rec = sb.pop_front();
            checks++;
            if (observed() !== exp_rec || !eth_parser_info_vld)
                $display("[TB] FAIL b2b_record: got %h vld %b expected %h", observed(), eth_parser_info_vld, exp_rec);
            else passed++;
            pop_head();
        end
    endtask

    initial begin
        checks             = 0;
        passed             = 0;
        reset              = 1'b0;
        in_data            = '0;
        word_MAC_DA        = 1'b0;
        word_ETH_TYPE      = 1'b0;
        word_VLAN_INNER    = 1'b0;
        eth_parser_rd_info = 1'b0;
        for (int i = 0; i < 4; i++) port_mac[i] = 48'h02AA_0000_0010 + 48'(i);

        test_reset();
        test_unicast_match();
        test_broadcast();
        test_no_match();
        test_vlan();
        test_overrun();
        test_fifo_full();
        test_reset_mid_search();
        test_back_to_back();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
